// File: rtl/spi_fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// spi_fifo_tx_drain : SPI mode-0 master draining a show-ahead 25-bit FIFO
// Revision: 1.0
// ============================================================================
module spi_fifo_tx_drain #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic        clock,
   input  logic        sclr,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [24:0] fifo_q,
   output logic        fifo_rdreq,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic        busy,
   output logic        word_done
);

   localparam int C_MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int C_MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int C_MAX_P  = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
   localparam int CW       = (C_MAX_P > 1) ? $clog2(C_MAX_P) : 1;
   // The IDLE pop cycle is the final gap cycle, so GAP itself lasts CS_GAP-1
   localparam int C_GAP_LAST_I = (CS_GAP > 1) ? CS_GAP - 2 : 0;

   localparam logic [CW-1:0] C_DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] C_HOLD_LAST  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] C_GAP_LAST   = CW'(C_GAP_LAST_I);

   localparam logic [2:0] C_ST_IDLE  = 3'd0;
   localparam logic [2:0] C_ST_SETUP = 3'd1;
   localparam logic [2:0] C_ST_SHIFT = 3'd2;
   localparam logic [2:0] C_ST_HOLD  = 3'd3;
   localparam logic [2:0] C_ST_GAP   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic          phase_q, phase_d;
   logic [23:0]   shreg_q, shreg_d;
   logic          keep_q, keep_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          cs_n_q, cs_n_d;
   logic          word_done_q, word_done_d;
   logic          w_rdreq;
   logic          w_pop_ok;

   assign w_pop_ok = enable & ~fifo_empty & ~sclr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      shreg_d = shreg_q;
      keep_d  = keep_q;
      w_rdreq = 1'b0;
      case (state_q)
         C_ST_IDLE: begin
            if (w_pop_ok) begin
               w_rdreq = 1'b1;
               shreg_d = fifo_q[23:0];
               keep_d  = fifo_q[24];
               state_d = C_ST_SETUP;
               cnt_d   = '0;
            end
         end
         C_ST_SETUP: begin
            if (cnt_q == C_SETUP_LAST) begin
               state_d = C_ST_SHIFT;
               cnt_d   = '0;
               phase_d = 1'b0;
               bit_d   = 5'd23;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         C_ST_SHIFT: begin
            if (cnt_q != C_DIV_LAST) begin
               cnt_d = cnt_q + CW'(1);
            end else if (!phase_q) begin
               cnt_d   = '0;
               phase_d = 1'b1;
            end else begin
               cnt_d   = '0;
               phase_d = 1'b0;
               shreg_d = {shreg_q[22:0], 1'b0};
               if (bit_q != 5'd0) begin
                  bit_d = bit_q - 5'd1;
               end else if (keep_q && w_pop_ok) begin
                  // Chained word: reload and restart at bit 23 inside the same frame
                  w_rdreq = 1'b1;
                  shreg_d = fifo_q[23:0];
                  keep_d  = fifo_q[24];
                  bit_d   = 5'd23;
               end else begin
                  state_d = C_ST_HOLD;
               end
            end
         end
         C_ST_HOLD: begin
            if (cnt_q == C_HOLD_LAST) begin
               cnt_d   = '0;
               state_d = (CS_GAP > 1) ? C_ST_GAP : C_ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         C_ST_GAP: begin
            if (cnt_q == C_GAP_LAST) begin
               cnt_d   = '0;
               state_d = C_ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = C_ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with it
   always_comb begin
      cs_n_d      = ~((state_d == C_ST_SETUP) || (state_d == C_ST_SHIFT) ||
                      (state_d == C_ST_HOLD));
      sclk_d      = (state_d == C_ST_SHIFT) && phase_d;
      mosi_d      = ((state_d == C_ST_SETUP) || (state_d == C_ST_SHIFT)) ? shreg_d[23] : 1'b0;
      word_done_d = (state_d == C_ST_SHIFT) && phase_d && (bit_d == 5'd0) &&
                    (cnt_d == C_DIV_LAST);
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state_q     <= C_ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         phase_q     <= 1'b0;
         shreg_q     <= '0;
         keep_q      <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         phase_q     <= phase_d;
         shreg_q     <= shreg_d;
         keep_q      <= keep_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         cs_n_q      <= cs_n_d;
         word_done_q <= word_done_d;
      end
   end

   assign fifo_rdreq = w_rdreq;
   assign busy       = (state_q != C_ST_IDLE);
   assign sclk       = sclk_q;
   assign mosi       = mosi_q;
   assign cs_n       = cs_n_q;
   assign word_done  = word_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// tb_spi_fifo_tx_drain : bench for the SPI FIFO drain engine (two parameter sets)
// Revision: 1.0
// ============================================================================
module tb_spi_fifo_tx_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        sclr, enable, sel;
   logic        fe0, fe6;
   logic [24:0] fifo_q;
   logic        rd0, sclk0, mosi0, cs0, busy0, wd0;
   logic        rd6, sclk6, mosi6, cs6, busy6, wd6;
   logic        m_rd, m_sclk, m_mosi, m_cs_n, m_busy, m_wd, m_fe;

   spi_fifo_tx_drain #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(2)) dut (
      .clock(clk), .sclr(sclr), .enable(enable), .fifo_empty(fe0), .fifo_q(fifo_q),
      .fifo_rdreq(rd0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs0), .busy(busy0),
      .word_done(wd0));

   spi_fifo_tx_drain #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut6 (
      .clock(clk), .sclr(sclr), .enable(enable), .fifo_empty(fe6), .fifo_q(fifo_q),
      .fifo_rdreq(rd6), .sclk(sclk6), .mosi(mosi6), .cs_n(cs6), .busy(busy6),
      .word_done(wd6));

   assign m_rd   = sel ? rd6   : rd0;
   assign m_sclk = sel ? sclk6 : sclk0;
   assign m_mosi = sel ? mosi6 : mosi0;
   assign m_cs_n = sel ? cs6   : cs0;
   assign m_busy = sel ? busy6 : busy0;
   assign m_wd   = sel ? wd6   : wd0;
   assign m_fe   = sel ? fe6   : fe0;

   typedef struct {
      logic [3:0][24:0] w;
      int n;
      int fr;
      int low0;
   } vec_t;
   vec_t tbl[5];

   logic [24:0] fq[$];
   logic [24:0] stim[$];
   logic [23:0] words[$];
   int          frames[$];
   int          gaps[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, rd_cnt = 0, wd_cnt = 0, cur_low = 0, cur_high = 0, nbits = 0, last_rise = 0;
   int p_div = 2, p_setup = 1, p_hold = 1, p_gap = 2;
   bit prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   bit aborted = 1'b0, have_frame = 1'b0, pend_wd = 1'b0, post_rst_chk = 1'b0, rd_seen = 1'b0;
   logic [23:0] bits = '0;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic refresh();
      fifo_q = (fq.size() > 0) ? fq[0] : 25'h0;
      fe0    = sel ? 1'b1 : (fq.size() == 0);
      fe6    = sel ? (fq.size() == 0) : 1'b1;
   endtask

   task automatic set_sel(input bit s);
      sel     = s;
      p_div   = s ? 1 : 2;
      p_setup = 1;
      p_hold  = 1;
      p_gap   = s ? 1 : 2;
      refresh();
   endtask

   // Observes the active DUT's pins at the falling edge
   task automatic monitor();
      if (post_rst_chk) begin
         check("rst_cs_n", m_cs_n, 1);
         check("rst_sclk", m_sclk, 0);
         check("rst_mosi", m_mosi, 0);
         check("rst_busy", m_busy, 0);
         check("rst_word_done", m_wd, 0);
         post_rst_chk = 1'b0;
      end
      if (m_rd || sclr) check("rdreq_guard", int'(m_rd & (m_fe | sclr | ~enable)), 0);
      if (m_rd) rd_cnt++;
      if (sclr) begin
         if (!m_cs_n) aborted = 1'b1;
         nbits   = 0;
         pend_wd = 1'b0;
      end
      if (!m_cs_n) begin
         if (prev_cs) begin
            if (have_frame) gaps.push_back(cur_high);
            cur_low = 0;
         end
         cur_low++;
      end else begin
         if (!prev_cs) begin
            if (!aborted) begin
               frames.push_back(cur_low);
               have_frame = 1'b1;
            end
            aborted  = 1'b0;
            cur_high = 0;
         end
         cur_high++;
      end
      if (m_sclk && !prev_sclk) begin
         check("sclk_in_frame", m_cs_n, 0);
         bits = {bits[22:0], m_mosi};
         nbits++;
         if (nbits == 24) begin
            words.push_back(bits);
            nbits     = 0;
            last_rise = cyc;
            pend_wd   = 1'b1;
         end
      end
      if (m_sclk && prev_sclk) check("mosi_stable_high", m_mosi, prev_mosi);
      if (m_wd) begin
         wd_cnt++;
         check("word_done_pending", pend_wd, 1);
         check("word_done_timing", cyc - last_rise, p_div - 1);
         pend_wd = 1'b0;
      end
      prev_cs   = m_cs_n;
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
      rd_seen   = m_rd;
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      monitor();
      @(posedge clk);
      #1;
      if (rd_seen && fq.size() > 0) void'(fq.pop_front());
      refresh();
   endtask

   task automatic clear_mon();
      words.delete();
      frames.delete();
      gaps.delete();
      rd_cnt     = 0;
      wd_cnt     = 0;
      have_frame = 1'b0;
      nbits      = 0;
   endtask

   task automatic wait_idle(input bit need_empty);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (!((!need_empty || fq.size() == 0) && !m_busy) && k < 20000);
      if (k >= 20000) check("idle_timeout", 1, 0);
      repeat (3) cycle();
   endtask

   // Reference: a frame chains consecutive words while keep=1 and another word is queued
   task automatic verify(input string tag);
      int ef[$];
      int i = 0;
      while (i < stim.size()) begin
         int n = 1;
         while (stim[i][24] && i + 1 < stim.size()) begin
            n++;
            i++;
         end
         ef.push_back(p_setup + 48 * p_div * n + p_hold);
         i++;
      end
      check({tag, "_frames"}, frames.size(), ef.size());
      for (int k = 0; k < frames.size() && k < ef.size(); k++)
         check({tag, "_frame_len"}, frames[k], ef[k]);
      check({tag, "_gaps"}, gaps.size(), ef.size() - 1);
      for (int k = 0; k < gaps.size(); k++) check({tag, "_gap_len"}, gaps[k], p_gap);
      check({tag, "_words"}, words.size(), stim.size());
      for (int k = 0; k < words.size() && k < stim.size(); k++)
         check({tag, "_data"}, int'(words[k]), int'(stim[k][23:0]));
      check({tag, "_rdreq_cnt"}, rd_cnt, stim.size());
      check({tag, "_word_done_cnt"}, wd_cnt, stim.size());
   endtask

   task automatic run_case(input string tag);
      clear_mon();
      foreach (stim[k]) fq.push_back(stim[k]);
      enable = 1'b1;
      refresh();
      wait_idle(1'b1);
      verify(tag);
   endtask

   task automatic set_vec(input int i, input int n, input int fr, input int low0,
                          input logic [24:0] a, input logic [24:0] b, input logic [24:0] c);
      tbl[i].w[0] = a;
      tbl[i].w[1] = b;
      tbl[i].w[2] = c;
      tbl[i].w[3] = 25'h0;
      tbl[i].n    = n;
      tbl[i].fr   = fr;
      tbl[i].low0 = low0;
   endtask

   initial begin
      int k;
      set_vec(0, 1, 1,  98, 25'h0A5A5A5, 25'h0, 25'h0);
      set_vec(1, 2, 1, 194, 25'h1123456, 25'h0ABCDEF, 25'h0);
      set_vec(2, 3, 1, 290, 25'h1000001, 25'h1800000, 25'h0555555);
      set_vec(3, 2, 2,  98, 25'h0FFFFFF, 25'h0000000, 25'h0);
      set_vec(4, 3, 2, 194, 25'h1ABCDEF, 25'h0123456, 25'h1654321);

      // Reset with a word waiting and enable high: nothing may be popped
      sclr   = 1'b1;
      enable = 1'b1;
      set_sel(1'b0);
      fq.push_back(25'h0A5A5A5);
      refresh();
      cycle();
      post_rst_chk = 1'b1;
      cycle();
      cycle();
      check("reset_no_rdreq", rd_cnt, 0);
      fq.delete();
      enable = 1'b0;
      sclr   = 1'b0;
      refresh();
      cycle();

      for (int t = 0; t < 5; t++) begin
         stim.delete();
         for (int j = 0; j < tbl[t].n; j++) stim.push_back(tbl[t].w[j]);
         run_case("tbl");
         check("tbl_frames_hand", frames.size(), tbl[t].fr);
         if (frames.size() > 0) check("tbl_low0_hand", frames[0], tbl[t].low0);
      end

      // Keep=1 word with nothing behind it closes the frame; a later word opens a new one
      clear_mon();
      fq.push_back(25'h1FFFFFF);
      enable = 1'b1;
      refresh();
      wait_idle(1'b1);
      repeat (5) cycle();
      fq.push_back(25'h0123456);
      refresh();
      wait_idle(1'b1);
      check("keep_empty_frames", frames.size(), 2);
      if (frames.size() == 2) begin
         check("keep_empty_low0", frames[0], 98);
         check("keep_empty_low1", frames[1], 98);
      end
      if (gaps.size() > 0) check("keep_empty_gap_min", int'(gaps[0] >= p_gap), 1);
      if (words.size() == 2) begin
         check("keep_empty_w0", int'(words[0]), 24'hFFFFFF);
         check("keep_empty_w1", int'(words[1]), 24'h123456);
      end

      // Reset during bit 10 discards the word in flight
      clear_mon();
      fq.push_back(25'h0C3C3C3);
      fq.push_back(25'h0F0F0F0);
      enable = 1'b1;
      refresh();
      k = 0;
      while (nbits != 13 && k < 2000) begin
         cycle();
         k++;
      end
      check("reset_reach_bit10", nbits, 13);
      sclr = 1'b1;
      cycle();
      sclr         = 1'b0;
      post_rst_chk = 1'b1;
      wait_idle(1'b1);
      check("reset_words", words.size(), 1);
      if (words.size() > 0) check("reset_next_word", int'(words[0]), 24'hF0F0F0);
      check("reset_frames", frames.size(), 1);
      if (frames.size() > 0) check("reset_frame_len", frames[0], 98);
      check("reset_rdreq_cnt", rd_cnt, 2);

      // Enable gating, then enable dropped during the first word of a keep chain
      clear_mon();
      enable = 1'b0;
      fq.push_back(25'h13C3C3C);
      fq.push_back(25'h15A5A5A);
      fq.push_back(25'h00F0F0F);
      refresh();
      repeat (20) cycle();
      check("gated_rdreq", rd_cnt, 0);
      check("gated_cs_n", m_cs_n, 1);
      check("gated_frames", frames.size(), 0);
      enable = 1'b1;
      k = 0;
      while (nbits == 0 && k < 200) begin
         cycle();
         k++;
      end
      enable = 1'b0;
      wait_idle(1'b0);
      check("drop_rdreq", rd_cnt, 1);
      check("drop_fifo_left", fq.size(), 2);
      check("drop_frames", frames.size(), 1);
      if (frames.size() > 0) check("drop_frame_len", frames[0], 98);
      check("drop_words", words.size(), 1);
      if (words.size() > 0) check("drop_word", int'(words[0]), 24'h3C3C3C);
      stim.delete();
      stim.push_back(25'h15A5A5A);
      stim.push_back(25'h00F0F0F);
      clear_mon();
      enable = 1'b1;
      wait_idle(1'b1);
      verify("resume");

      // Minimal timing parameters on the second instance
      set_sel(1'b1);
      stim.delete();
      stim.push_back(25'h0000001);
      stim.push_back(25'h0800000);
      run_case("div1");
      if (gaps.size() > 0) check("div1_gap_exact", gaps[0], 1);

      for (int r = 0; r < 8; r++) begin
         int n;
         set_sel(r[0]);
         stim.delete();
         n = 1 + int'($urandom_range(0, 3));
         for (int j = 0; j < n; j++) stim.push_back(25'($urandom));
         run_case("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
